// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the otter instruction fetch unit.
package otter_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int          FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] INSTR_BYTES         = 32'd4;

endpackage

// File: rtl/otter_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module otter_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wptr, r_rptr;
  logic [CW-1:0]               r_count;
  logic                        w_wr, w_rd;

  assign w_wr  = push & ~flush;
  assign w_rd  = pop & ~flush & (r_count != '0);
  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/otter_fetch_buf.sv
// Fetch PC, credit-based imem issue and prefetch queue feeding decode.
// OTTER_FETCH_BYPASS_EN: present a response arriving into an empty queue on id_* the same cycle.
module otter_fetch_buf
  import otter_fetch_pkg::*;
#(
  parameter int          DEPTH     = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_rden,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc,
  output logic [31:0] id_instr
);
  localparam int CW = $clog2(DEPTH + 1);

  logic         r_inflight;
  logic [31:0]  r_fetch_pc, r_issue_pc;
  logic [CW-1:0] w_count;
  logic         w_empty, w_push, w_fpop, w_pop, w_byp, w_credit;
  logic [CW:0]  w_used, w_limit;
  logic [31:0]  w_redir_pc;
  fetch_entry_t w_wr, w_rd, w_head;
  logic         w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^redirect_addr[1:0];
  assign w_redir_pc        = {redirect_addr[31:2], 2'b00};
  assign w_wr              = '{pc: r_issue_pc, instr: imem_rdata};

  always_comb begin
    w_byp = 1'b0;
`ifdef OTTER_FETCH_BYPASS_EN
    w_byp = w_empty & r_inflight & ~redirect_valid;
`endif
    id_valid = ~w_empty | w_byp;
    w_head   = w_empty ? w_wr : w_rd;
    w_pop    = id_valid & id_ready;
    // A bypassed word taken by decode this cycle never touches storage.
    w_push   = r_inflight & ~redirect_valid & ~(w_byp & id_ready);
    w_fpop   = id_ready & ~w_empty;
  end

  // Credit counts the in-flight read so the queue can never overflow.
  always_comb begin
    w_used   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    w_limit  = (CW + 1)'(DEPTH) + {{CW{1'b0}}, w_pop};
    w_credit = (w_used < w_limit);
  end

  assign imem_rden = ~RST & (redirect_valid | w_credit);
  assign imem_addr = (redirect_valid & ~RST) ? w_redir_pc : r_fetch_pc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_pc <= RESET_VEC;
      r_issue_pc <= RESET_VEC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_rden;
      if (imem_rden) begin
        r_issue_pc <= imem_addr;
        r_fetch_pc <= imem_addr + INSTR_BYTES;
      end
    end
  end

  otter_sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_queue (
    .clk  (CLK),
    .rst  (RST),
    .flush(redirect_valid),
    .push (w_push),
    .wdata(w_wr),
    .pop  (w_fpop),
    .rdata(w_rd),
    .count(w_count),
    .empty(w_empty)
  );

  assign id_pc    = id_valid ? w_head.pc : 32'h0;
  assign id_npc   = id_valid ? (w_head.pc + INSTR_BYTES) : 32'h0;
  assign id_instr = id_valid ? w_head.instr : 32'h0;

endmodule

// File: tb/tb_otter_fetch_buf.sv
// Self-checking bench: queue-based reference model plus directed literal checks and random traffic.
module tb_otter_fetch_buf;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        CLK, RST, redirect_valid, imem_rden, id_valid, id_ready;
  logic [31:0] redirect_addr, imem_addr, imem_rdata, id_pc, id_npc, id_instr;

  otter_fetch_buf #(.DEPTH(DEPTH), .RESET_VEC(RV)) dut (
    .CLK(CLK), .RST(RST),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_rden(imem_rden), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_npc(id_npc), .id_instr(id_instr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Synchronous instruction memory.
  always @(posedge CLK) if (imem_rden) imem_rdata <= mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  bit          m_inf;
  logic [31:0] m_ipc, m_fpc;
  int          checks, errors;
  logic        s_rden, s_valid;
  logic [31:0] s_addr, s_pc, s_npc, s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    m_inf = 0;
    m_ipc = RV;
    m_fpc = RV;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model at the edge.
  task automatic step(input bit rv, input logic [31:0] ra, input bit rdy);
    ent_t        head;
    bit          e_valid, e_rden, pop, byp;
    logic [31:0] e_addr;
    int          used;
    @(negedge CLK);
    redirect_valid = rv;
    redirect_addr  = ra;
    id_ready       = rdy;
    #1;
    byp = 0;
    if (mq.size() > 0) begin
      e_valid = 1; head = mq[0];
    end
`ifdef OTTER_FETCH_BYPASS_EN
    else if (m_inf && !rv) begin
      e_valid = 1; byp = 1; head = '{m_ipc, mem_word(m_ipc)};
    end
`endif
    else begin
      e_valid = 0; head = '{32'h0, 32'h0};
    end
    pop    = e_valid && rdy;
    used   = mq.size() + int'(m_inf) - int'(pop);
    e_rden = rv || (used < DEPTH);
    e_addr = rv ? {ra[31:2], 2'b00} : m_fpc;

    s_rden = imem_rden; s_addr = imem_addr; s_valid = id_valid;
    s_pc = id_pc; s_npc = id_npc; s_instr = id_instr;
    chk("imem_rden", 32'(s_rden), 32'(e_rden));
    if (e_rden) chk("imem_addr", s_addr, e_addr);
    chk("id_valid", 32'(s_valid), 32'(e_valid));
    chk("id_pc", s_pc, e_valid ? head.pc : 32'h0);
    chk("id_npc", s_npc, e_valid ? head.pc + 32'd4 : 32'h0);
    chk("id_instr", s_instr, e_valid ? head.instr : 32'h0);

    @(posedge CLK);
    if (rv) mq.delete();
    else begin
      if (pop && !byp) void'(mq.pop_front());
      if (m_inf && !(byp && pop)) mq.push_back('{m_ipc, mem_word(m_ipc)});
    end
    m_inf = e_rden;
    if (e_rden) begin
      m_ipc = e_addr;
      m_fpc = e_addr + 32'd4;
    end
  endtask

  // Asynchronous assertion between edges; outputs must clear before the next edge.
  task automatic do_reset;
    @(negedge CLK);
    redirect_valid = 0;
    #2 RST = 1'b1;
    #1;
    chk("rst_rden", 32'(imem_rden), 32'h0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_npc", id_npc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
  endtask

  task automatic check_restart;
    step(0, 0, 0);
    chk("c0_rden", 32'(s_rden), 32'h1);
    chk("c0_addr", s_addr, RV);
    step(0, 0, 0);
`ifdef OTTER_FETCH_BYPASS_EN
    chk("c1_valid", 32'(s_valid), 32'h1);
    chk("c1_pc", s_pc, RV);
    step(0, 0, 0);
`else
    chk("c1_valid", 32'(s_valid), 32'h0);
    step(0, 0, 0);
    chk("c2_valid", 32'(s_valid), 32'h1);
    chk("c2_pc", s_pc, RV);
    chk("c2_npc", s_npc, RV + 32'd4);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit stale;
    int i;
    checks = 0; errors = 0;
    RST = 1'b1; redirect_valid = 0; redirect_addr = 0; id_ready = 0; imem_rdata = 0;
    model_reset();

    // Reset latency, then stall until the queue holds DEPTH entries.
    do_reset();
    check_restart();
    for (i = 0; i < 7; i++) step(0, 0, 0);
    chk("stall_rden", 32'(s_rden), 32'h0);
    chk("stall_valid", 32'(s_valid), 32'h1);
    chk("stall_head", s_pc, 32'h0);
    chk("model_held", 32'(mq.size()), 32'd4);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1);
      chk("drain_valid", 32'(s_valid), 32'h1);
      chk("drain_pc", s_pc, 32'(k * 4));
    end

    // Redirect with 3 queued and one in flight.
    for (i = 0; i < 20 && !(mq.size() == 3 && m_inf); i++) step(0, 0, 0);
    chk("reach_q3", 32'(mq.size() == 3 && m_inf), 32'h1);
    step(1, 32'h100, 0);
    for (i = 0; i < 10 && !(mq.size() > 0); i++) step(0, 0, 1);
    step(0, 0, 1);
    chk("redir_pc", s_pc, 32'h100);
    stale = (s_valid && s_pc < 32'h100);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1);
      if (s_valid && s_pc < 32'h100) stale = 1;
    end
    chk("no_stale", 32'(stale), 32'h0);

    // Redirect to an unaligned target while decode is popping.
    for (i = 0; i < 10 && !(mq.size() > 0); i++) step(0, 0, 1);
    step(1, 32'h203, 1);
    chk("pop_redir_valid", 32'(s_valid), 32'h1);
    chk("redir_addr", s_addr, 32'h200);
    for (i = 0; i < 10; i++) begin
      step(0, 0, 1);
      if (s_valid) break;
    end
    chk("redir2_pc", s_pc, 32'h200);
    chk("redir2_npc", s_npc, 32'h204);
    chk("redir2_instr", s_instr, mem_word(32'h200));

    // Fetch PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFF8, 1);
    step(0, 0, 1);
    chk("wrap_iss_top", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 1);
    chk("wrap_iss_zero", s_addr, 32'h0);
    for (i = 0; i < 10 && !(s_valid && s_pc == 32'hFFFF_FFFC); i++) step(0, 0, 1);
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_npc", s_npc, 32'h0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bit          rv, rdy;
      logic [31:0] ra;
      rv  = ($urandom_range(0, 19) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      step(rv, ra, rdy);
    end

    // Asynchronous reset with two entries queued.
    step(1, 32'h40, 0);
    for (i = 0; i < 10 && mq.size() != 2; i++) step(0, 0, 0);
    chk("reach_q2", 32'(mq.size()), 32'd2);
    do_reset();
    check_restart();
    for (int k = 0; k < 20; k++) step(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
